// File: rtl/flappy_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : flappy_pkg
//  Brief    : Screen/sprite constants, pipe word layout and game state codes
//             shared by the pipe scheduler and the display block.
//  Revision : 1.0
// ============================================================================
package flappy_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int PIPE_W   = 50;
    localparam int CHAR_W   = 16;
    localparam int CHAR_H   = 16;
    localparam int MARIO_X  = 70;

    localparam int HEIGHT_LSB = 0;
    localparam int ADDR_LSB   = 10;
    localparam int GAP_LSB    = 20;
    localparam int VIS_BIT    = 31;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_RUN    = 2'd1;
    localparam state_t ST_FREEZE = 2'd2;

    // Bits [30:28] stay zero.
    function automatic logic [31:0] pipe_word(input logic       vis,
                                              input logic [7:0] gap,
                                              input logic [9:0] addr,
                                              input logic [9:0] h);
        logic [31:0] w;
        w                    = '0;
        w[HEIGHT_LSB +: 10]  = h;
        w[ADDR_LSB   +: 10]  = addr;
        w[GAP_LSB    +: 8]   = gap;
        w[VIS_BIT]           = vis;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_lfsr.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_lfsr
//  Brief    : 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running.
//  Revision : 1.0
// ============================================================================
module pipe_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        clrn,
    output logic [15:0] lfsr
);

    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end

    assign lfsr = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/pipe_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_scheduler
//  Brief    : Scrolls and respawns three pipe groups, keeps score and a
//             sticky collision flag against the mario sprite column.
//  Revision : 1.0
// ============================================================================
module pipe_scheduler #(
    parameter int          SCREEN_W  = flappy_pkg::SCREEN_W,
    parameter int          PIPE_W    = flappy_pkg::PIPE_W,
    parameter int          SPACING   = 230,
    parameter int          SPEED     = 2,
    parameter int          H_MIN     = 100,
    parameter int          GAP       = 100,
    parameter int          MARIO_X   = flappy_pkg::MARIO_X,
    parameter int          CHAR_W    = flappy_pkg::CHAR_W,
    parameter int          CHAR_H    = flappy_pkg::CHAR_H,
    parameter int          SCREEN_H  = flappy_pkg::SCREEN_H,
    parameter int          PARK_X    = 700,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          SCORE_MAX = 9999
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        tick,
    input  logic        start,
    input  logic        stop,
    input  logic [9:0]  mario_y,
    output logic [31:0] pipe_1,
    output logic [31:0] pipe_2,
    output logic [31:0] pipe_3,
    output logic [15:0] score,
    output logic        score_pulse,
    output logic        hit,
    output logic [1:0]  state
);
    import flappy_pkg::*;

    localparam logic signed [11:0] c_park_pos  = 12'(SCREEN_W + 2 * SPACING);
    localparam logic signed [11:0] c_screen_w  = 12'(SCREEN_W);
    localparam logic signed [11:0] c_pipe_w    = 12'(PIPE_W);
    localparam logic signed [11:0] c_neg_pw    = 12'(-PIPE_W);
    localparam logic signed [11:0] c_speed     = 12'(SPEED);
    localparam logic signed [11:0] c_loop      = 12'(3 * SPACING);
    localparam logic signed [11:0] c_mario_x   = 12'(MARIO_X);
    localparam logic signed [11:0] c_mario_r   = 12'(MARIO_X + CHAR_W - 1);
    localparam logic [9:0]         c_h_min     = 10'(H_MIN);
    localparam logic [7:0]         c_gap       = 8'(GAP);
    localparam logic [9:0]         c_park_x    = 10'(PARK_X);
    localparam logic [15:0]        c_score_max = 16'(SCORE_MAX);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_init;
    logic             w_advance;
    logic [15:0]      w_lfsr;
    logic [2:0][7:0]  w_rnd;
    logic [2:0][31:0] w_words;
    logic [2:0]       w_score;
    logic [2:0]       w_col;
    logic [10:0]      w_my_top;
    logic [10:0]      w_my_bot;
    logic             w_floor;
    logic [15:0]      r_score;
    logic             r_pulse;
    logic             r_hit;

    pipe_lfsr #(.SEED(SEED)) u_lfsr (
        .clk  (clk),
        .clrn (clrn),
        .lfsr (w_lfsr)
    );

    // Distinct slices so pipes respawning on the same tick differ in height.
    assign w_rnd = {w_lfsr[15:8], w_lfsr[11:4], w_lfsr[7:0]};

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_state_next = ST_RUN;
            ST_RUN:    if (start) w_state_next = ST_RUN;
                       else if (stop) w_state_next = ST_FREEZE;
            ST_FREEZE: if (start) w_state_next = ST_RUN;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_init    = 1'b0;
        w_advance = 1'b0;
        case (r_state)
            ST_IDLE, ST_FREEZE: w_init = start;
            ST_RUN: begin
                w_init    = start;
                w_advance = tick & ~start;
            end
            default: ;
        endcase
    end

    assign w_my_top = {1'b0, mario_y};
    assign w_my_bot = w_my_top + 11'(CHAR_H);
    assign w_floor  = w_my_bot > 11'(SCREEN_H);

    for (genvar gi = 0; gi < 3; gi++) begin : g_pipe
        logic signed [11:0] r_pos;
        logic [9:0]         r_h;
        logic signed [11:0] w_step;
        logic signed [11:0] w_new;
        logic               w_wrap;
        logic [9:0]         w_h_new;
        logic [10:0]        w_h_bot;
        logic               w_vis;

        assign w_step  = r_pos - c_speed;
        assign w_wrap  = w_step < c_neg_pw;
        assign w_new   = w_wrap ? w_step + c_loop : w_step;
        assign w_h_new = w_wrap ? c_h_min + {2'b00, w_rnd[gi]} : r_h;
        assign w_h_bot = {1'b0, w_h_new} + {3'b000, c_gap};

        assign w_score[gi] = (r_pos + c_pipe_w >= c_mario_x) &&
                             (w_new + c_pipe_w < c_mario_x);
        assign w_col[gi]   = (w_new < c_screen_w) && (w_new <= c_mario_r) &&
                             (w_new + c_pipe_w > c_mario_x) &&
                             ((w_my_top < {1'b0, w_h_new}) || (w_my_bot > w_h_bot));

        always_ff @(posedge clk or negedge clrn) begin
            if (!clrn) begin
                r_pos <= c_park_pos;
                r_h   <= c_h_min;
            end else if (w_init) begin
                r_pos <= 12'(SCREEN_W + gi * SPACING);
                r_h   <= c_h_min + {2'b00, w_lfsr[7:0]};
            end else if (w_advance) begin
                r_pos <= w_new;
                r_h   <= w_h_new;
            end
        end

        // Negative positions wrap through [9:0] so the display draws a partial pipe.
        assign w_vis       = r_pos < c_screen_w;
        assign w_words[gi] = pipe_word(w_vis, c_gap, w_vis ? r_pos[9:0] : c_park_x, r_h);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_score <= '0;
            r_pulse <= 1'b0;
            r_hit   <= 1'b0;
        end else begin
            r_pulse <= w_advance && (|w_score);
            if (w_init) begin
                r_score <= '0;
                r_hit   <= 1'b0;
            end else if (w_advance) begin
                if ((|w_score) && (r_score < c_score_max)) begin
                    r_score <= r_score + 16'd1;
                end
                if ((|w_col) || w_floor) begin
                    r_hit <= 1'b1;
                end
            end
        end
    end

    assign pipe_1      = w_words[0];
    assign pipe_2      = w_words[1];
    assign pipe_3      = w_words[2];
    assign score       = r_score;
    assign score_pulse = r_pulse;
    assign hit         = r_hit;
    assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pipe_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_scheduler
//  Brief    : Directed vector table plus hand sequences for pipe_scheduler.
//  Revision : 1.0
// ============================================================================
module tb_pipe_scheduler;

    logic        clk = 1'b0;
    logic        clrn, tick, start, stop;
    logic [9:0]  mario_y;
    logic [31:0] pipe_1, pipe_2, pipe_3;
    logic [15:0] score;
    logic        score_pulse, hit;
    logic [1:0]  state;
    logic [31:0] d2_p1, d2_p2, d2_p3;
    logic [15:0] d2_score;
    logic        d2_pulse, d2_hit;
    logic [1:0]  d2_state;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] m_lfsr;
    logic [9:0]  exp_h;

    always #5 clk = ~clk;

    pipe_scheduler dut (
        .clk(clk), .clrn(clrn), .tick(tick), .start(start), .stop(stop),
        .mario_y(mario_y), .pipe_1(pipe_1), .pipe_2(pipe_2), .pipe_3(pipe_3),
        .score(score), .score_pulse(score_pulse), .hit(hit), .state(state)
    );

    pipe_scheduler #(.SCORE_MAX(1)) dut_sat (
        .clk(clk), .clrn(clrn), .tick(tick), .start(start), .stop(stop),
        .mario_y(mario_y), .pipe_1(d2_p1), .pipe_2(d2_p2), .pipe_3(d2_p3),
        .score(d2_score), .score_pulse(d2_pulse), .hit(d2_hit), .state(d2_state)
    );

    // Reference LFSR: x^16+x^14+x^13+x^11, shifting left.
    always @(posedge clk or negedge clrn) begin
        if (!clrn) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    typedef struct {
        logic       s, p, t;
        logic [1:0] st;
        logic       v1;
        logic [9:0] a1;
        logic       v2;
        logic [9:0] a2;
        logic       chk_h;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic p, input logic t);
        start = s; stop = p; tick = t;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; stop = 1'b0; tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] reset_word;
        reset_word = {1'b0, 3'b000, 8'd100, 10'd700, 10'd100};

        //            s     p     t     st    v1    a1       v2    a2       chk_h
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 10'd700, 1'b0, 10'd700, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 10'd700, 1'b0, 10'd700, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 10'd700, 1'b0, 10'd700, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 10'd638, 1'b0, 10'd700, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 10'd638, 1'b0, 10'd700, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 10'd636, 1'b0, 10'd700, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 10'd634, 1'b0, 10'd700, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 10'd632, 1'b0, 10'd700, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 10'd630, 1'b0, 10'd700, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 10'd628, 1'b0, 10'd700, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 10'd628, 1'b0, 10'd700, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 10'd700, 1'b0, 10'd700, 1'b1};

        clrn = 1'b0; tick = 1'b0; start = 1'b0; stop = 1'b0; mario_y = 10'd200;
        repeat (3) @(negedge clk);
        clrn = 1'b1;

        chk("reset_state", 32'(state), 32'd0);
        chk("reset_pipe_1", pipe_1, reset_word);
        chk("reset_pipe_3", pipe_3, reset_word);
        chk("reset_score", 32'(score), 32'd0);
        chk("reset_hit_pulse", {30'd0, hit, score_pulse}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].s) exp_h = 10'd100 + {2'b00, m_lfsr[7:0]};
            cyc(tbl[i].s, tbl[i].p, tbl[i].t);
            chk($sformatf("v%0d_state", i), 32'(state), 32'(tbl[i].st));
            chk($sformatf("v%0d_p1_vis", i), 32'(pipe_1[31]), 32'(tbl[i].v1));
            chk($sformatf("v%0d_p1_addr", i), 32'(pipe_1[19:10]), 32'(tbl[i].a1));
            chk($sformatf("v%0d_p2_vis", i), 32'(pipe_2[31]), 32'(tbl[i].v2));
            chk($sformatf("v%0d_p2_addr", i), 32'(pipe_2[19:10]), 32'(tbl[i].a2));
            chk($sformatf("v%0d_p3_hi", i), 32'(pipe_3[31:10]), {10'd0, 12'd100, 10'd700});
            chk($sformatf("v%0d_p1_gap", i), 32'(pipe_1[30:20]), 32'd100);
            if (tbl[i].chk_h) begin
                chk($sformatf("v%0d_h1", i), 32'(pipe_1[9:0]), 32'(exp_h));
                chk($sformatf("v%0d_h2", i), 32'(pipe_2[9:0]), 32'(exp_h));
                chk($sformatf("v%0d_h3", i), 32'(pipe_3[9:0]), 32'(exp_h));
            end
        end

        // Run after restart: pipe_1 from 640 crosses the sprite at 20->18.
        ticks(310);
        chk("pre_cross_addr", 32'(pipe_1[19:10]), 32'd20);
        chk("pre_cross_score", 32'(score), 32'd0);
        ticks(1);
        chk("cross_score", 32'(score), 32'd1);
        chk("cross_pulse", 32'(score_pulse), 32'd1);
        chk("sat_dut_first", 32'(d2_score), 32'd1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("pulse_drop", 32'(score_pulse), 32'd0);
        chk("score_hold", 32'(score), 32'd1);
        ticks(34);
        chk("edge_p1_addr", 32'(pipe_1[19:10]), 32'd974);
        chk("edge_p1_vis", 32'(pipe_1[31]), 32'd1);
        exp_h = 10'd100 + {2'b00, m_lfsr[7:0]};
        ticks(1);
        chk("respawn_p1_addr", 32'(pipe_1[19:10]), 32'd638);
        chk("respawn_p1_h", 32'(pipe_1[9:0]), 32'(exp_h));
        chk("respawn_p2_addr", 32'(pipe_2[19:10]), 32'd178);
        chk("respawn_p3_addr", 32'(pipe_3[19:10]), 32'd408);
        chk("respawn_p3_vis", 32'(pipe_3[31]), 32'd1);
        ticks(80);
        chk("second_point", 32'(score), 32'd2);
        chk("sat_dut_holds", 32'(d2_score), 32'd1);

        // Collision: stay inside pipe_1's gap until it reaches x=60.
        exp_h = 10'd100 + {2'b00, m_lfsr[7:0]};
        cyc(1'b1, 1'b0, 1'b0);
        chk("restart_h1", 32'(pipe_1[9:0]), 32'(exp_h));
        chk("restart_hit_score", {15'd0, hit, score}, 32'd0);
        mario_y = exp_h + 10'd40;
        ticks(289);
        chk("in_gap_addr", 32'(pipe_1[19:10]), 32'd62);
        chk("in_gap_hit", 32'(hit), 32'd0);
        mario_y = 10'd10;
        ticks(1);
        chk("collide_addr", 32'(pipe_1[19:10]), 32'd60);
        chk("collide_hit", 32'(hit), 32'd1);
        mario_y = 10'd200;
        cyc(1'b0, 1'b1, 1'b0);
        chk("stop_state", 32'(state), 32'd2);
        ticks(3);
        chk("frozen_addr", 32'(pipe_1[19:10]), 32'd60);
        chk("frozen_hit", 32'(hit), 32'd1);
        cyc(1'b1, 1'b0, 1'b0);
        chk("reinit_state", 32'(state), 32'd1);
        chk("reinit_hit_score", {15'd0, hit, score}, 32'd0);
        chk("reinit_p1", 32'(pipe_1[31:10]), {10'd0, 12'd100, 10'd700});

        // Floor boundary: 464+16=480 is safe, 465+16 is not.
        mario_y = 10'd464;
        ticks(1);
        chk("floor_edge_hit", 32'(hit), 32'd0);
        mario_y = 10'd465;
        ticks(1);
        chk("floor_hit", 32'(hit), 32'd1);

        // Asynchronous reset between edges.
        #2;
        clrn = 1'b0;
        #1;
        chk("async_state", 32'(state), 32'd0);
        chk("async_pipe_1", pipe_1, reset_word);
        chk("async_pipe_2", pipe_2, reset_word);
        chk("async_score_hit", {15'd0, hit, score}, 32'd0);
        @(negedge clk);
        clrn = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
